bridge_arbiter: RTL and testbench
=================================

Name: bridge_arbiter

Overview:
- Shares the single DRAM bridge port (C_addr / C_data_w / C_r_wb / C_in_valid / C_out_valid / C_data_r) between NREQ requesters.
- Requester 0 is the farm system; requester 1 is the land scanner / deposit auditor.
- Each requester has a one-deep request buffer. Grants are round-robin, and only one bridge transaction is outstanding at a time.
- A timeout guards against a hung bridge. Responses are routed back to the requester that owns the transaction.

Parameters:
NREQ, 2, number of requesters (2..4)
TIMEOUT, 1023, maximum WAIT cycles before an error response (1..65535)
TW, 16, timeout counter width; must satisfy 2^TW > TIMEOUT

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  NREQ  per-requester request strobe
req_ready  out  NREQ  buffer i empty; a request is accepted when req_valid[i] && req_ready[i]
req_addr  in  8*NREQ  land id or 255 (deposit); slice i = [8i+7:8i]
req_r_wb  in  NREQ  1 = read, 0 = write
req_data_w  in  32*NREQ  write data, passed through byte-exact
rsp_valid  out  NREQ  one-cycle completion pulse to the owning requester
rsp_data_r  out  32  read data; valid only with rsp_valid
rsp_err  out  1  timeout indication, qualified by rsp_valid
busy  out  1  state != IDLE
stray_flag  out  1  sticky: C_out_valid received outside WAIT
C_addr  out  8  bridge address
C_data_w  out  32  bridge write data
C_r_wb  out  1  bridge direction
C_in_valid  out  1  one-cycle bridge command pulse
C_out_valid  in  1  bridge completion
C_data_r  in  32  bridge read data

Behaviour:
- Reset values: every output 0 (C_addr, C_data_w, rsp_data_r included). req_ready = all ones. Buffers empty. State IDLE. rr_ptr = 0. stray_flag = 0.
- Reset mid-transaction: the transaction is abandoned with no rsp_valid. A later C_out_valid sets stray_flag.
- Buffers:
  - req_ready[i] = !pend[i].
  - An accepted request latches addr, r_wb and data_w, and sets pend[i] at that edge.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any pend bit is set, grant the first set index found scanning rr_ptr, rr_ptr+1, … modulo NREQ.
  - On the grant: load C_addr, C_data_w, C_r_wb from that buffer; record owner; go to ISSUE.
  - A request accepted at edge k can be granted at edge k+1 at the earliest. C_in_valid then rises in the following cycle.
- ISSUE:
  - C_in_valid = 1 for exactly this cycle.
  - Clear the timeout counter; go to WAIT.
- WAIT:
  - If C_out_valid: capture C_data_r into rsp_data_r (always captured; writes return the bridge value); rsp_err = 0; go to RESP.
  - Else if cnt == TIMEOUT − 1: rsp_err = 1, rsp_data_r = 0; go to RESP.
  - Else cnt++.
  - C_out_valid wins over timeout in the same cycle.
- RESP:
  - rsp_valid[owner] = 1 for one cycle.
  - Clear pend[owner] at the end of the cycle, so req_ready[owner] rises in the next cycle.
  - rr_ptr = (owner + 1) mod NREQ; go to IDLE.
  - Back-to-back throughput: 3 overhead cycles plus bridge latency per transaction.
- C_addr, C_data_w and C_r_wb hold their values from grant until the next grant. They are not cleared.
- rsp_data_r and rsp_err hold their values after RESP.
- C_out_valid in IDLE, ISSUE or RESP:
  - Ignored for data.
  - Sets stray_flag, which is cleared only by rst.
- Starvation bound: with all requesters continuously pending, each requester is served within NREQ grants.
- No address hazard checking. Write-then-read ordering to the same address holds only within a single requester, because each requester has one buffer and one outstanding transaction.
- No endian conversion: the byte swap remains the requester's responsibility.

Decomposition:
- Shared package:
  - arb_state_t enum {IDLE, ISSUE, WAIT, RESP}
  - MODE_READ = 1'b1, MODE_WRITE = 1'b0
  - DEPOSIT_ADDR = 8'd255
  - bridge_req_t struct {addr[7:0], r_wb, data_w[31:0]}
- One natural sub-module: rr_pick.
  - Combinational round-robin priority select.
  - Inputs: pend[NREQ], rr_ptr. Outputs: grant index, any_pend.
  - Reused later for other shared resources.
- Buffers, FSM, counter and response routing stay in bridge_arbiter.

Test Plan:
1. Single read: req0 addr 255 read → one C_in_valid pulse with C_addr 255, C_r_wb 1. Bridge returns 0x00001000 after 5 cycles → rsp_valid[0] one cycle later, rsp_data_r 0x00001000, rsp_err 0.
2. Simultaneous: req0 (write addr 3, 0xAABBCCDD) and req1 (read addr 7) in the same cycle, rr_ptr 0 → addr 3 issued first, addr 7 second. Next simultaneous pair → req1 first.
3. Back-pressure: req_valid[0] held high during an outstanding req0 → req_ready[0] low until the cycle after rsp_valid[0]. No duplicate issue.
4. Timeout with TIMEOUT = 8: the bridge never answers → rsp_valid[0] with rsp_err 1 and data 0. A late C_out_valid in IDLE sets stray_flag; the next transaction is unaffected.
5. Reset mid-WAIT: rst for 1 cycle → all outputs 0, req_ready all ones, no rsp_valid. A new request afterwards completes normally.
6. Fairness: both requesters re-request immediately after each response for 20 transactions → issue order alternates 0,1,0,1…

Source files
------------

// File: rtl/bridge_arbiter_pkg.sv
// Shared types for the DRAM bridge arbiter and its round-robin picker.
// Also holds the bridge mode/address constants that requesters use.
package bridge_arbiter_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;

  localparam logic       MODE_READ    = 1'b1;
  localparam logic       MODE_WRITE   = 1'b0;
  localparam logic [7:0] DEPOSIT_ADDR = 8'd255;

  typedef struct packed {
    logic [7:0]  addr;
    logic        r_wb;
    logic [31:0] data_w;
  } bridge_req_t;

  // Width of a requester index for 2..4 requesters.
  function automatic int idx_w(input int n);
    return (n > 2) ? 2 : 1;
  endfunction

endpackage

// File: rtl/bridge_arbiter_rr_pick.sv
// Combinational round-robin select: first set pend bit at or after rr_ptr, wrapping.
// Zero latency; no flow control of its own.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] pend,
  input  logic [IW-1:0]   rr_ptr,
  output logic [IW-1:0]   grant,
  output logic            any_pend
);

  // Scan from the far end back to rr_ptr so the nearest set bit is assigned last.
  always_comb begin
    int idx;
    idx      = 0;
    grant    = '0;
    any_pend = |pend;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (pend[idx]) grant = IW'(idx);
    end
  end

endmodule

// File: rtl/bridge_arbiter.sv
// Shares one DRAM bridge port among NREQ requesters; one-deep buffer each, one transaction in flight.
// Issue one cycle after grant; req_ready[i] stays low from accept until the cycle after rsp_valid[i].
module bridge_arbiter
  import bridge_arbiter_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 1023,
  parameter int TW      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [8*NREQ-1:0]    req_addr,
  input  logic [NREQ-1:0]      req_r_wb,
  input  logic [32*NREQ-1:0]   req_data_w,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [31:0]          rsp_data_r,
  output logic                 rsp_err,
  output logic                 busy,
  output logic                 stray_flag,
  output logic [7:0]           C_addr,
  output logic [31:0]          C_data_w,
  output logic                 C_r_wb,
  output logic                 C_in_valid,
  input  logic                 C_out_valid,
  input  logic [31:0]          C_data_r
);

  localparam int IW = idx_w(NREQ);

  arb_state_t      state, state_nxt;
  logic [NREQ-1:0] pend;
  bridge_req_t     req_buf [NREQ];
  logic [IW-1:0]   rr_ptr, owner, pick;
  logic            any_pend;
  logic [TW-1:0]   cnt;
  logic            done_ok, done_to;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .pend     (pend),
    .rr_ptr   (rr_ptr),
    .grant    (pick),
    .any_pend (any_pend)
  );

  assign req_ready = ~pend;
  // A bridge answer in the same cycle as the timeout wins.
  assign done_ok   = (state == WAIT) && C_out_valid;
  assign done_to   = (state == WAIT) && !C_out_valid && (cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_pend) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (done_ok || done_to) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    C_in_valid = 1'b0;
    rsp_valid  = '0;
    busy       = (state != IDLE);
    case (state)
      ISSUE:   C_in_valid = 1'b1;
      RESP:    rsp_valid[owner] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend       <= '0;
      rr_ptr     <= '0;
      owner      <= '0;
      cnt        <= '0;
      C_addr     <= '0;
      C_data_w   <= '0;
      C_r_wb     <= 1'b0;
      rsp_data_r <= '0;
      rsp_err    <= 1'b0;
      stray_flag <= 1'b0;
      for (int i = 0; i < NREQ; i++) req_buf[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && !pend[i]) begin
          pend[i]    <= 1'b1;
          req_buf[i] <= '{addr:   req_addr[8*i +: 8],
                          r_wb:   req_r_wb[i],
                          data_w: req_data_w[32*i +: 32]};
        end
      end

      // Bridge command fields hold from one grant to the next.
      if (state == IDLE && any_pend) begin
        owner    <= pick;
        C_addr   <= req_buf[pick].addr;
        C_data_w <= req_buf[pick].data_w;
        C_r_wb   <= req_buf[pick].r_wb;
      end

      if (state == ISSUE)                       cnt <= '0;
      else if (state == WAIT && !done_ok && !done_to) cnt <= cnt + 1'b1;

      if (done_ok) begin
        rsp_data_r <= C_data_r;
        rsp_err    <= 1'b0;
      end else if (done_to) begin
        rsp_data_r <= '0;
        rsp_err    <= 1'b1;
      end

      if (state == RESP) begin
        pend[owner] <= 1'b0;
        rr_ptr      <= (int'(owner) == NREQ - 1) ? '0 : owner + 1'b1;
      end

      if (C_out_valid && state != WAIT) stray_flag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bridge_arbiter.sv
// Directed bench for bridge_arbiter with two requesters and an 8-cycle timeout.
module tb_bridge_arbiter;
  import bridge_arbiter_pkg::*;

  localparam int NREQ = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, req_r_wb, rsp_valid;
  logic [15:0] req_addr;
  logic [63:0] req_data_w;
  logic [31:0] rsp_data_r, C_data_w, C_data_r;
  logic        rsp_err, busy, stray_flag, C_r_wb, C_in_valid, C_out_valid;
  logic [7:0]  C_addr;
  int          n_cmp = 0;
  int          n_err = 0;
  int          t_iss;

  always #5 clk = ~clk;

  bridge_arbiter #(.NREQ(NREQ), .TIMEOUT(8), .TW(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_r_wb(req_r_wb), .req_data_w(req_data_w),
    .rsp_valid(rsp_valid), .rsp_data_r(rsp_data_r), .rsp_err(rsp_err),
    .busy(busy), .stray_flag(stray_flag),
    .C_addr(C_addr), .C_data_w(C_data_w), .C_r_wb(C_r_wb),
    .C_in_valid(C_in_valid), .C_out_valid(C_out_valid), .C_data_r(C_data_r)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic rw, input logic [31:0] d);
    req_addr[8*i +: 8]    = a;
    req_r_wb[i]           = rw;
    req_data_w[32*i +: 32] = d;
  endtask

  // Waits (bounded) for the command pulse and checks the bridge fields.
  task automatic wait_issue(input string tag, input logic [7:0] a, input logic rw,
                            input logic [31:0] d, output int t);
    t = 0;
    do begin
      tick();
      t++;
    end while (!C_in_valid && t < 20);
    chk({tag, "_issue"}, 64'(C_in_valid), 64'(1));
    chk({tag, "_addr"},  64'(C_addr),     64'(a));
    chk({tag, "_rwb"},   64'(C_r_wb),     64'(rw));
    chk({tag, "_dataw"}, 64'(C_data_w),   64'(d));
  endtask

  // Bridge answers in the lat-th cycle after the command; ends in the response cycle.
  task automatic bridge_reply(input string tag, input int lat, input logic [31:0] d,
                              input logic [1:0] mask);
    tick();
    chk({tag, "_pulse1"}, 64'(C_in_valid), 64'(0));
    tick(lat - 1);
    C_out_valid = 1'b1;
    C_data_r    = d;
    tick();
    C_out_valid = 1'b0;
    C_data_r    = '0;
    chk({tag, "_rspv"}, 64'(rsp_valid),  64'(mask));
    chk({tag, "_rspd"}, 64'(rsp_data_r), 64'(d));
    chk({tag, "_err"},  64'(rsp_err),    64'(0));
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_addr = '0; req_r_wb = '0; req_data_w = '0;
    C_out_valid = 1'b0; C_data_r = '0;
    tick(2);
    chk("rst_ready", 64'(req_ready),  64'(2'b11));
    chk("rst_rspv",  64'(rsp_valid),  64'(0));
    chk("rst_busy",  64'(busy),       64'(0));
    chk("rst_stray", 64'(stray_flag), 64'(0));
    chk("rst_cin",   64'(C_in_valid), 64'(0));
    chk("rst_caddr", 64'(C_addr),     64'(0));
    chk("rst_cdw",   64'(C_data_w),   64'(0));
    chk("rst_rspd",  64'(rsp_data_r), 64'(0));
    rst = 1'b0;

    // Simultaneous pair with rr_ptr 0: requester 0 first.
    set_req(0, 8'd3, MODE_WRITE, 32'hAABBCCDD);
    set_req(1, 8'd7, MODE_READ,  32'h11112222);
    req_valid = 2'b11;
    tick();
    req_valid = 2'b00;
    chk("t2_accept", 64'(req_ready), 64'(2'b00));
    wait_issue("t2a0", 8'd3, MODE_WRITE, 32'hAABBCCDD, t_iss);
    bridge_reply("t2a0", 2, 32'h5A5A0001, 2'b01);
    wait_issue("t2a1", 8'd7, MODE_READ, 32'h11112222, t_iss);
    bridge_reply("t2a1", 3, 32'h00770077, 2'b10);
    tick();
    chk("t2_idle_ready", 64'(req_ready), 64'(2'b11));

    // Single deposit read, bridge latency 5.
    set_req(0, DEPOSIT_ADDR, MODE_READ, 32'h0);
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    wait_issue("t1", DEPOSIT_ADDR, MODE_READ, 32'h0, t_iss);
    chk("t1_issue_lat", 64'(t_iss), 64'(1));
    bridge_reply("t1", 5, 32'h00001000, 2'b01);
    tick();
    chk("t1_rspv_once", 64'(rsp_valid),  64'(0));
    chk("t1_rspd_hold", 64'(rsp_data_r), 64'(32'h00001000));

    // Second pair after serving requester 0: requester 1 first.
    set_req(0, 8'd4, MODE_WRITE, 32'h01020304);
    set_req(1, 8'd8, MODE_READ,  32'h0);
    req_valid = 2'b11;
    tick();
    req_valid = 2'b00;
    wait_issue("t2b1", 8'd8, MODE_READ, 32'h0, t_iss);
    bridge_reply("t2b1", 1, 32'h88880008, 2'b10);
    wait_issue("t2b0", 8'd4, MODE_WRITE, 32'h01020304, t_iss);
    bridge_reply("t2b0", 4, 32'h44440004, 2'b01);
    tick();

    // Back-pressure: req_valid[0] held high through the transaction.
    set_req(0, 8'd5, MODE_READ, 32'h0);
    req_valid = 2'b01;
    tick();
    wait_issue("t3", 8'd5, MODE_READ, 32'h0, t_iss);
    chk("t3_ready_iss", 64'(req_ready), 64'(2'b10));
    tick();
    chk("t3_cin_once",   64'(C_in_valid), 64'(0));
    chk("t3_ready_wait", 64'(req_ready),  64'(2'b10));
    tick(2);
    C_out_valid = 1'b1; C_data_r = 32'h00000033;
    tick();
    C_out_valid = 1'b0; C_data_r = '0;
    chk("t3_rspv",       64'(rsp_valid), 64'(2'b01));
    chk("t3_ready_resp", 64'(req_ready), 64'(2'b10));
    tick();
    chk("t3_ready_back", 64'(req_ready), 64'(2'b11));
    req_valid = 2'b00;
    tick(3);
    chk("t3_no_dup", 64'(busy), 64'(0));

    // Timeout: bridge silent for 8 WAIT cycles.
    set_req(0, 8'd6, MODE_READ, 32'h0);
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    wait_issue("t4", 8'd6, MODE_READ, 32'h0, t_iss);
    tick(8);
    chk("t4_pre_rspv", 64'(rsp_valid), 64'(0));
    chk("t4_pre_busy", 64'(busy),      64'(1));
    tick();
    chk("t4_rspv", 64'(rsp_valid),  64'(2'b01));
    chk("t4_err",  64'(rsp_err),    64'(1));
    chk("t4_rspd", 64'(rsp_data_r), 64'(0));
    tick();
    chk("t4_idle", 64'(busy), 64'(0));
    C_out_valid = 1'b1; C_data_r = 32'h0000DEAD;
    tick();
    C_out_valid = 1'b0; C_data_r = '0;
    chk("t4_stray",     64'(stray_flag), 64'(1));
    chk("t4_stray_rsp", 64'(rsp_valid),  64'(0));
    chk("t4_stray_dat", 64'(rsp_data_r), 64'(0));
    set_req(0, 8'd9, MODE_WRITE, 32'h12345678);
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    wait_issue("t4n", 8'd9, MODE_WRITE, 32'h12345678, t_iss);
    bridge_reply("t4n", 2, 32'hCAFEF00D, 2'b01);
    chk("t4_stray_sticky", 64'(stray_flag), 64'(1));
    tick();

    // Reset in the middle of WAIT.
    set_req(1, 8'h20, MODE_READ, 32'h0);
    req_valid = 2'b10;
    tick();
    req_valid = 2'b00;
    wait_issue("t5", 8'h20, MODE_READ, 32'h0, t_iss);
    tick(2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rspv",  64'(rsp_valid),  64'(0));
    chk("t5_busy",  64'(busy),       64'(0));
    chk("t5_ready", 64'(req_ready),  64'(2'b11));
    chk("t5_caddr", 64'(C_addr),     64'(0));
    chk("t5_crwb",  64'(C_r_wb),     64'(0));
    chk("t5_cdw",   64'(C_data_w),   64'(0));
    chk("t5_rspd",  64'(rsp_data_r), 64'(0));
    chk("t5_stray", 64'(stray_flag), 64'(0));
    chk("t5_cin",   64'(C_in_valid), 64'(0));
    tick();
    C_out_valid = 1'b1; C_data_r = 32'h00000001;
    tick();
    C_out_valid = 1'b0; C_data_r = '0;
    chk("t5_late_stray", 64'(stray_flag), 64'(1));
    chk("t5_late_rspv",  64'(rsp_valid),  64'(0));
    set_req(0, 8'h21, MODE_READ, 32'h0);
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    wait_issue("t5n", 8'h21, MODE_READ, 32'h0, t_iss);
    bridge_reply("t5n", 3, 32'h0BADBEEF, 2'b01);
    tick();

    // Fairness: both requesters always re-requesting; rr_ptr starts at 1.
    set_req(0, 8'd10, MODE_WRITE, 32'hA0A0A0A0);
    set_req(1, 8'd11, MODE_READ,  32'h0);
    req_valid = 2'b11;
    for (int k = 0; k < 21; k++) begin
      int e;
      e = (k + 1) % 2;
      wait_issue($sformatf("t6_%0d", k), (e == 0) ? 8'd10 : 8'd11,
                 (e == 0) ? MODE_WRITE : MODE_READ,
                 (e == 0) ? 32'hA0A0A0A0 : 32'h0, t_iss);
      bridge_reply($sformatf("t6_%0d", k), 1 + (k % 3), 32'(k), 2'(1 << e));
      if (k == 19) req_valid = 2'b00;
    end
    tick(2);
    chk("t6_drain_busy",  64'(busy),      64'(0));
    chk("t6_drain_ready", 64'(req_ready), 64'(2'b11));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
